// File: rtl/mb_pkg.sv
// rtl/mb_pkg.sv - shared types and helpers for the sequential Booth multiplier
package mb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CORR = 2'd2
    } state_t;

    // Bit positions inside the recoded-digit control word
    localparam int BD_ONE = 0;
    localparam int BD_TWO = 1;
    localparam int BD_NEG = 2;
    localparam int BD_W   = 3;

    // Unsigned operands need one extra digit to consume the zero-extended top bits
    function automatic int digit_count(input int width, input logic is_signed);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/mb_seq_mult_if.sv
// rtl/mb_seq_mult_if.sv - start/busy/done operand and result bundle
interface mb_seq_mult_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    modport master (output start, signed_mode, a, b, input busy, done, p);
    modport slave  (input start, signed_mode, a, b, output busy, done, p);
endinterface

// File: rtl/mb_booth_digit.sv
// rtl/mb_booth_digit.sv - radix-4 Booth recoder for one multiplier triplet
module mb_booth_digit
    import mb_pkg::*;
(
    input  logic [2:0]      triplet,
    output logic [BD_W-1:0] ctl
);

    // neg follows the top bit even for 111, so a -0 digit still needs its +1 correction
    always_comb begin
        ctl         = '0;
        ctl[BD_ONE] = triplet[1] ^ triplet[0];
        ctl[BD_TWO] = (triplet == 3'b011) || (triplet == 3'b100);
        ctl[BD_NEG] = triplet[2];
    end

endmodule

// File: rtl/mb_seq_mult.sv
// rtl/mb_seq_mult.sv - iterative radix-4 Booth multiplier, one digit per clock
module mb_seq_mult
    import mb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    mb_seq_mult_if.slave  bus
);

    localparam int AW = 2 * WIDTH + 2;
    localparam int MW = WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $fatal(1, "mb_seq_mult: WIDTH must be even and at least 4");
    end

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [AW-1:0]      cor_q, cor_d;
    logic [MW-1:0]      a_q, a_d;
    logic [BW-1:0]      b_q, b_d;
    logic               mode_q, mode_d;
    logic [CW-1:0]      i_q, i_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;

    logic [BD_W-1:0]    ctl;
    logic [MW-1:0]      mag;
    logic [MW-1:0]      pp;
    logic [AW-1:0]      pp_sx;
    logic               last_digit;

    // b_q shifts right two bits per digit, so the live triplet is always b_q[2:0]
    mb_booth_digit u_digit (
        .triplet (b_q[2:0]),
        .ctl     (ctl)
    );

    always_comb begin
        mag        = ctl[BD_ONE] ? a_q : (ctl[BD_TWO] ? (a_q << 1) : '0);
        pp         = ctl[BD_NEG] ? ~mag : mag;
        pp_sx      = {{(AW - MW){pp[MW-1]}}, pp};
        last_digit = (i_q == CW'(digit_count(WIDTH, mode_q) - 1));
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cor_d   = cor_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        i_d     = i_q;
        p_d     = p_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.signed_mode;
                    a_d     = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
                    b_d     = {(bus.signed_mode ? {2{bus.b[WIDTH-1]}} : 2'b00), bus.b, 1'b0};
                    acc_d   = '0;
                    cor_d   = '0;
                    i_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + (pp_sx << {i_q, 1'b0});
                cor_d = cor_q | (AW'(ctl[BD_NEG]) << {i_q, 1'b0});
                b_d   = {2'b00, b_q[BW-1:2]};
                i_d   = i_q + 1'b1;
                if (last_digit) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                p_d     = acc_q[2*WIDTH-1:0] + cor_q[2*WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cor_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            i_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cor_q   <= cor_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            i_q     <= i_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.p    = p_q;

endmodule
